fetch_unit: RTL and testbench

Instruction fetch stage that feeds the decoder. It holds the program counter and issues word reads to instruction memory with at most one request in flight. Returned words are buffered with their PC in a small FIFO and presented to the decoder through a valid/ready handshake. Branch and jump redirects from control flush the FIFO and drop any in-flight response.

---
 rtl/fetch_unit.sv | 131 +++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: program counter, single-outstanding instruction memory reads,
// and a small {pc, word} FIFO presented to the decoder through a valid/ready handshake.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    output logic [31:0] instruction,
    output logic [31:0] inst_pc,
    input  logic        inst_ready
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam int               CNT_W    = $clog2(DEPTH + 1);
    localparam logic [31:0]      NOP      = 32'h0000_0013;
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic             outstanding_q, outstanding_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]      fifo_pc_q   [DEPTH];
    logic [31:0]      fifo_word_q [DEPTH];

    logic             resp;
    logic             push;
    logic             pop;
    logic             accept;
    logic [CNT_W:0]   occupancy;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    // A response is only meaningful while a request is outstanding; a stray rvalid is ignored.
    always_comb begin
        resp        = imem_rvalid && outstanding_q;
        inst_valid  = (count_q != '0);
        pop         = inst_valid && inst_ready && !redirect_valid;
        push        = resp && !discard_q && !redirect_valid;
        occupancy   = {1'b0, count_q} + {{CNT_W{1'b0}}, outstanding_q}
                    - {{CNT_W{1'b0}}, pop};
        imem_req    = !rst && !redirect_valid && (!outstanding_q || imem_rvalid)
                    && (occupancy < DEPTH_C);
        accept      = imem_req && imem_ready;
        imem_addr   = fetch_pc_q;
        instruction = inst_valid ? fifo_word_q[rd_ptr_q] : NOP;
        inst_pc     = inst_valid ? fifo_pc_q[rd_ptr_q] : 32'h0;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        count_d       = count_q;
        rd_ptr_d      = rd_ptr_q;
        wr_ptr_d      = wr_ptr_q;

        if (accept) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = fetch_pc_q + 32'd4;
        end else if (resp) begin
            outstanding_d = 1'b0;
        end

        if (resp && discard_q) discard_d = 1'b0;
        if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Redirect wins: flush, retarget, and poison a response that has not come back yet.
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            discard_d  = outstanding_q && !imem_rvalid;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            outstanding_q <= 1'b0;
            discard_q     <= 1'b0;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
        end
    end

    // FIFO storage carries no reset; the outputs are masked by inst_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]   <= req_pc_q;
            fifo_word_q[wr_ptr_q] <= imem_rdata;
        end
    end

    assert property (@(posedge clk) disable iff (rst) !(push && count_q == FULL));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, hand-written redirect/reset sequences,
// and a randomized run checked against a stream-level model of fetch and delivery order.
module tb_fetch_unit;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] instruction;
    logic [31:0] inst_pc;
    logic        inst_ready;

    fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .instruction    (instruction),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Per-cycle stimulus knobs
    logic        drv_iready, drv_redir, drv_mrdy;
    logic [31:0] drv_rpc;
    int          lat;

    // Memory model: one read at a time, answered lat cycles after acceptance
    logic        mem_busy;
    logic [31:0] mem_addr;
    int          mem_due;
    int          cyc;

    // Stream-level reference: next address to fetch, next pc to deliver
    logic [31:0] exp_fetch, exp_cons;
    logic        prev_redir;
    int          stall;

    // Values sampled in the current cycle
    logic        s_req, s_valid, s_rvalid;
    logic [31:0] s_addr, s_pc, s_instr;

    typedef struct {
        logic        iready;
        logic        req;
        logic [31:0] addr;
        logic        valid;
        logic [31:0] pc;
    } vec_t;
    vec_t tbl[$];

    function automatic vec_t row(input logic ir, input logic rq, input logic [31:0] ad,
                                 input logic v, input logic [31:0] pc);
        vec_t r;
        r.iready = ir; r.req = rq; r.addr = ad; r.valid = v; r.pc = pc;
        return r;
    endfunction

    function automatic logic [31:0] tag(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_5A3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int limit);
        total++;
        bad++;
        $display("FAIL %s: waited %0d cycles, limit %0d (t=%0t)", name, act, limit, $time);
    endtask

    task automatic model_reset();
        mem_busy   = 1'b0;
        mem_addr   = 32'h0;
        mem_due    = 0;
        exp_fetch  = RESET_PC;
        exp_cons   = RESET_PC;
        prev_redir = 1'b0;
        stall      = 0;
    endtask

    // One clock cycle: apply inputs just after the edge, check on the falling edge, update model.
    task automatic step();
        logic fire, popv;
        inst_ready     = drv_iready;
        redirect_valid = drv_redir;
        redirect_pc    = drv_rpc;
        imem_ready     = drv_mrdy;
        imem_rvalid    = mem_busy && (cyc == mem_due);
        imem_rdata     = imem_rvalid ? tag(mem_addr) : $urandom;
        @(negedge clk);
        s_req = imem_req; s_addr = imem_addr; s_valid = inst_valid;
        s_pc = inst_pc; s_instr = instruction; s_rvalid = imem_rvalid;

        if (prev_redir) chkb("flush_after_redirect", inst_valid, 1'b0);
        if (redirect_valid) chkb("no_req_on_redirect", imem_req, 1'b0);
        if (mem_busy && !imem_rvalid) chkb("one_in_flight", imem_req, 1'b0);
        if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
        if (inst_valid) begin
            chk("head_pc", inst_pc, exp_cons);
            chk("head_word", instruction, tag(exp_cons));
        end else begin
            chk("idle_word", instruction, NOP);
            chk("idle_pc", inst_pc, 32'h0);
        end

        fire = imem_req && imem_ready;
        popv = inst_valid && inst_ready && !redirect_valid;
        if (inst_ready && !redirect_valid && !inst_valid) stall++;
        else stall = 0;
        if (stall > 40) begin
            fail_now("liveness", stall, 40);
            stall = 0;
        end

        @(posedge clk);
        #1;
        if (s_rvalid) mem_busy = 1'b0;
        if (fire) begin
            mem_busy = 1'b1;
            mem_addr = s_addr;
            mem_due  = cyc + lat;
        end
        if (popv) exp_cons = exp_cons + 32'd4;
        if (drv_redir) begin
            exp_cons  = {drv_rpc[31:2], 2'b00};
            exp_fetch = {drv_rpc[31:2], 2'b00};
        end else if (fire) begin
            exp_fetch = exp_fetch + 32'd4;
        end
        prev_redir = drv_redir;
        cyc++;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: time %0t exceeded", $time);
        $fatal(1);
    end

    initial begin
        bit found;
        rst = 1'b1;
        imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
        drv_iready = 1'b1; drv_redir = 1'b0; drv_mrdy = 1'b1; drv_rpc = 32'h0;
        lat = 1; cyc = 0;
        model_reset();

        // Streaming, then 10 cycles of back-pressure, then release
        tbl.push_back(row(1'b1, 1'b1, 32'd0,  1'b0, 32'd0));
        tbl.push_back(row(1'b1, 1'b1, 32'd4,  1'b0, 32'd0));
        tbl.push_back(row(1'b1, 1'b1, 32'd8,  1'b1, 32'd0));
        tbl.push_back(row(1'b1, 1'b1, 32'd12, 1'b1, 32'd4));
        tbl.push_back(row(1'b1, 1'b1, 32'd16, 1'b1, 32'd8));
        tbl.push_back(row(1'b1, 1'b1, 32'd20, 1'b1, 32'd12));
        for (int i = 0; i < 10; i++) tbl.push_back(row(1'b0, 1'b0, 32'd24, 1'b1, 32'd16));
        tbl.push_back(row(1'b1, 1'b1, 32'd24, 1'b1, 32'd16));
        tbl.push_back(row(1'b1, 1'b1, 32'd28, 1'b1, 32'd20));
        tbl.push_back(row(1'b1, 1'b1, 32'd32, 1'b1, 32'd24));

        repeat (2) @(posedge clk);
        #1;
        chkb("rst_req", imem_req, 1'b0);
        chkb("rst_valid", inst_valid, 1'b0);
        chk("rst_instr", instruction, NOP);
        chk("rst_pc", inst_pc, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drv_iready = tbl[i].iready;
            step();
            chkb($sformatf("vec%0d_req", i), s_req, tbl[i].req);
            chk($sformatf("vec%0d_addr", i), s_addr, tbl[i].addr);
            chkb($sformatf("vec%0d_valid", i), s_valid, tbl[i].valid);
            chk($sformatf("vec%0d_pc", i), s_pc, tbl[i].pc);
            chk($sformatf("vec%0d_instr", i), s_instr, tbl[i].valid ? tag(tbl[i].pc) : NOP);
        end

        // Redirect while a slow read is still in flight
        lat = 3;
        drv_iready = 1'b1;
        step();
        drv_redir = 1'b1; drv_rpc = 32'h0000_0103;
        step();
        drv_redir = 1'b0; lat = 1;
        step();
        chkb("slow_redir_flush", s_valid, 1'b0);
        chk("slow_redir_addr", s_addr, 32'h0000_0100);
        found = 1'b0;
        for (int k = 0; k < 12 && !found; k++) begin
            step();
            if (s_valid) begin
                found = 1'b1;
                chk("slow_redir_head", s_pc, 32'h0000_0100);
            end
        end
        if (!found) fail_now("slow_redir_wait", 12, 12);

        // Redirect coinciding with a response and a would-be pop
        repeat (4) step();
        drv_redir = 1'b1; drv_rpc = 32'h0000_0200;
        step();
        chkb("rr_valid", s_valid, 1'b1);
        chkb("rr_req", s_req, 1'b0);
        drv_redir = 1'b0;
        step();
        chkb("rr_flush", s_valid, 1'b0);
        chkb("rr_req_next", s_req, 1'b1);
        chk("rr_addr", s_addr, 32'h0000_0200);
        repeat (3) step();

        // Address wrap at the top of the address space
        drv_redir = 1'b1; drv_rpc = 32'hFFFF_FFFE;
        step();
        drv_redir = 1'b0;
        step();
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        chkb("wrap_req0", s_req, 1'b1);
        step();
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        chkb("wrap_req1", s_req, 1'b1);
        repeat (4) step();

        // Fill the FIFO, then reset asynchronously mid-cycle
        drv_iready = 1'b0;
        repeat (4) step();
        chkb("sat_valid", s_valid, 1'b1);
        chkb("sat_req", s_req, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chkb("arst_valid", inst_valid, 1'b0);
        chk("arst_instr", instruction, NOP);
        chk("arst_pc", inst_pc, 32'h0);
        chkb("arst_req", imem_req, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        drv_iready = 1'b1;
        step();
        chkb("post_rst_req", s_req, 1'b1);
        chk("post_rst_addr", s_addr, RESET_PC);

        // Randomized traffic against the stream model
        for (int n = 0; n < 1500; n++) begin
            drv_iready = ($urandom_range(0, 3) != 0);
            drv_mrdy   = ($urandom_range(0, 3) != 0);
            drv_redir  = ($urandom_range(0, 15) == 0);
            drv_rpc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                     : 32'($urandom);
            lat        = $urandom_range(1, 3);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
